// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the cores and the central bus arbiter.
interface bus_arbiter_if #(
  parameter int unsigned NUM_CORES = 4
);
  localparam int unsigned OWNER_W = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0] D_Bus_RQ;
  logic [NUM_CORES-1:0] I_Bus_RQ;
  logic [NUM_CORES-1:0] D_Bus_GRANT;
  logic [NUM_CORES-1:0] I_Bus_GRANT;
  logic [OWNER_W-1:0]   D_Bus_Owner;
  logic [OWNER_W-1:0]   I_Bus_Owner;

  // Core side: raises requests, observes grants.
  modport master (
    output D_Bus_RQ, I_Bus_RQ,
    input  D_Bus_GRANT, I_Bus_GRANT, D_Bus_Owner, I_Bus_Owner
  );

  // Arbiter side: samples requests, drives grants.
  modport slave (
    input  D_Bus_RQ, I_Bus_RQ,
    output D_Bus_GRANT, I_Bus_GRANT, D_Bus_Owner, I_Bus_Owner
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared Data and Instruction buses.
// One engine per bus; a dead cycle always separates consecutive owners.

module bus_arbiter_engine #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned OWNER_W   = $clog2(NUM_CORES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] rq,
  output logic [NUM_CORES-1:0] grant,
  output logic [OWNER_W-1:0]   owner
);
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANTED    = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  state_t             state;
  logic [OWNER_W-1:0] ptr;
  logic [OWNER_W-1:0] idx_c;
  logic [OWNER_W-1:0] winner_c;
  logic [OWNER_W-1:0] next_ptr_c;
  logic               any_c;

  // First requester found scanning upward from ptr with wrap-around.
  always_comb begin
    any_c    = 1'b0;
    winner_c = '0;
    idx_c    = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx_c = OWNER_W'((32'(ptr) + k) % NUM_CORES);
      if (!any_c && rq[idx_c]) begin
        any_c    = 1'b1;
        winner_c = idx_c;
      end
    end
    next_ptr_c = OWNER_W'((32'(winner_c) + 32'd1) % NUM_CORES);
  end

  // Ownership FSM; turnaround arbitrates like idle but only after the dead cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE, TURNAROUND: begin
          if (any_c) begin
            grant <= NUM_CORES'(1) << winner_c;
            owner <= winner_c;
            ptr   <= next_ptr_c;
            state <= GRANTED;
          end else begin
            grant <= '0;
            state <= IDLE;
          end
        end
        GRANTED: begin
          if (!rq[owner]) begin
            grant <= '0;
            state <= TURNAROUND;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

module bus_arbiter #(
  parameter int unsigned NUM_CORES = 4
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  localparam int unsigned OWNER_W = $clog2(NUM_CORES);

  // Data bus engine.
  bus_arbiter_engine #(
    .NUM_CORES (NUM_CORES),
    .OWNER_W   (OWNER_W)
  ) u_d_engine (
    .clock (clock),
    .reset (reset),
    .rq    (bus.D_Bus_RQ),
    .grant (bus.D_Bus_GRANT),
    .owner (bus.D_Bus_Owner)
  );

  // Instruction bus engine, fully independent of the data engine.
  bus_arbiter_engine #(
    .NUM_CORES (NUM_CORES),
    .OWNER_W   (OWNER_W)
  ) u_i_engine (
    .clock (clock),
    .reset (reset),
    .rq    (bus.I_Bus_RQ),
    .grant (bus.I_Bus_GRANT),
    .owner (bus.I_Bus_Owner)
  );
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// compared against a transaction-level ownership model.
module tb_bus_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned OW = $clog2(N);

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  // Reference model: owner is -1 when the bus is free; pri is the first index to scan.
  int md_owner, md_pri, mi_owner, mi_pri;

  bus_arbiter_if #(.NUM_CORES(N)) bus ();

  bus_arbiter #(.NUM_CORES(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rq, input int start);
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = (start + k) % int'(N);
      if (rq[j]) return j;
    end
    return -1;
  endfunction

  // One bus per call: a released bus stays free for the edge it is released on.
  task automatic model_bus(input logic [N-1:0] rq, input bit rst, inout int owner, inout int pri);
    int w;
    if (rst) begin
      owner = -1;
      pri   = 0;
    end else if (owner >= 0) begin
      if (!rq[owner]) owner = -1;
    end else begin
      w = pick(rq, pri);
      if (w >= 0) begin
        owner = w;
        pri   = (w + 1) % int'(N);
      end
    end
  endtask

  function automatic logic [N-1:0] onehot_of(input int owner);
    logic [N-1:0] g;
    g = '0;
    if (owner >= 0) g[owner] = 1'b1;
    return g;
  endfunction

  task automatic compare_all();
    check("d_grant", 32'(bus.D_Bus_GRANT), 32'(onehot_of(md_owner)));
    check("i_grant", 32'(bus.I_Bus_GRANT), 32'(onehot_of(mi_owner)));
    check("d_onehot0", 32'($onehot0(bus.D_Bus_GRANT)), 32'd1);
    check("i_onehot0", 32'($onehot0(bus.I_Bus_GRANT)), 32'd1);
    if (md_owner >= 0) check("d_owner", 32'(bus.D_Bus_Owner), 32'(md_owner));
    if (mi_owner >= 0) check("i_owner", 32'(bus.I_Bus_Owner), 32'(mi_owner));
  endtask

  // Drive inputs at the falling edge, advance the model on the rising edge, sample 1 ns later.
  task automatic step(input logic [N-1:0] d, input logic [N-1:0] i, input bit rst);
    @(negedge clock);
    bus.D_Bus_RQ = d;
    bus.I_Bus_RQ = i;
    reset        = rst;
    @(posedge clock);
    model_bus(d, rst, md_owner, md_pri);
    model_bus(i, rst, mi_owner, mi_pri);
    #1;
    compare_all();
  endtask

  initial begin
    int          held;
    int          order[$];
    logic [N-1:0] prev_g;
    logic [N-1:0] rq;
    logic [N-1:0] rd, ri;
    int          exp_order[5];

    n_tests = 0;
    n_fail  = 0;
    md_owner = -1; md_pri = 0;
    mi_owner = -1; mi_pri = 0;
    reset        = 1'b1;
    bus.D_Bus_RQ = '0;
    bus.I_Bus_RQ = '0;

    // Reset held with every core requesting.
    step(4'b1111, 4'b1111, 1'b1);
    step(4'b1111, 4'b1111, 1'b1);
    check("rst_d_grant", 32'(bus.D_Bus_GRANT), 32'd0);
    check("rst_i_grant", 32'(bus.I_Bus_GRANT), 32'd0);
    check("rst_d_owner", 32'(bus.D_Bus_Owner), 32'd0);
    check("rst_i_owner", 32'(bus.I_Bus_Owner), 32'd0);
    step(4'b1111, 4'b1111, 1'b0);
    check("post_rst_d", 32'(bus.D_Bus_GRANT), 32'h1);

    // Single requester with release and immediate re-raise.
    step(4'b0000, 4'b0000, 1'b1);
    for (int c = 0; c < 6; c++) step(4'b0100, 4'b0000, 1'b0);
    check("single_hold", 32'(bus.D_Bus_GRANT), 32'h4);
    check("single_owner", 32'(bus.D_Bus_Owner), 32'd2);
    step(4'b0000, 4'b0000, 1'b0);
    check("single_drop", 32'(bus.D_Bus_GRANT), 32'h0);
    step(4'b0100, 4'b0000, 1'b0);
    check("single_regrant", 32'(bus.D_Bus_GRANT), 32'h4);

    // Round-robin: everyone requests, each owner lets go after 3 granted cycles.
    step(4'b0000, 4'b0000, 1'b1);
    held   = 0;
    prev_g = '0;
    for (int c = 0; c < 22; c++) begin
      rq = 4'b1111;
      if (md_owner >= 0 && held == 3) rq[md_owner] = 1'b0;
      step(rq, 4'b0000, 1'b0);
      held = (md_owner >= 0) ? held + 1 : 0;
      if (prev_g == '0 && bus.D_Bus_GRANT != '0) order.push_back(int'(bus.D_Bus_Owner));
      prev_g = bus.D_Bus_GRANT;
    end
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_count", 32'(order.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++)
      check("rr_order", (k < order.size()) ? 32'(order[k]) : 32'hffff_ffff, 32'(exp_order[k]));

    // Pointer wrap and no preemption.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1000, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) step(4'b1101, 4'b0000, 1'b0);
    check("nopreempt", 32'(bus.D_Bus_GRANT), 32'h8);
    step(4'b0101, 4'b0000, 1'b0);
    check("wrap_dead", 32'(bus.D_Bus_GRANT), 32'h0);
    step(4'b0101, 4'b0000, 1'b0);
    check("wrap_next", 32'(bus.D_Bus_GRANT), 32'h1);

    // Independent buses.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0010, 4'b1010, 1'b0);
    check("indep_d", 32'(bus.D_Bus_GRANT), 32'h2);
    check("indep_i", 32'(bus.I_Bus_GRANT), 32'h2);
    step(4'b0010, 4'b1000, 1'b0);
    step(4'b0010, 4'b1000, 1'b0);
    check("indep_i_next", 32'(bus.I_Bus_GRANT), 32'h8);
    check("indep_d_keep", 32'(bus.D_Bus_GRANT), 32'h2);

    // Reset in the middle of a tenure.
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0110, 4'b0110, 1'b1);
    check("midrst_d", 32'(bus.D_Bus_GRANT), 32'h0);
    check("midrst_i", 32'(bus.I_Bus_GRANT), 32'h0);
    step(4'b0110, 4'b0110, 1'b0);
    check("midrst_d_next", 32'(bus.D_Bus_GRANT), 32'h2);
    check("midrst_i_next", 32'(bus.I_Bus_GRANT), 32'h2);

    // Random traffic: requests toggle occasionally so tenures last several cycles.
    rd = '0;
    ri = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < int'(N); b++) begin
        if ($urandom_range(0, 3) == 0) rd[b] = ~rd[b];
        if ($urandom_range(0, 3) == 0) ri[b] = ~ri[b];
      end
      step(rd, ri, $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
